// File: rtl/ul_path_pkt_pkg.sv
// Shared types and helpers for the uplink-path packetizer: header layout,
// packer FSM states and the 34-bit store-and-forward FIFO entry.
package ul_path_pkt_pkg;

  localparam logic [7:0] HDR_SYNC      = 8'hA5;
  localparam int         HDR_SYNC_MSB  = 31;
  localparam int         HDR_SYNC_LSB  = 24;
  localparam int         HDR_TXANT_BIT = 23;
  localparam int         HDR_SEQ_MSB   = 15;
  localparam int         HDR_SEQ_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } pack_state_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } fifo_entry_t;

  function automatic logic [31:0] build_hdr(input logic txant, input logic [15:0] seq);
    logic [31:0] hdr;
    hdr = 32'h0000_0000;
    hdr[HDR_SYNC_MSB:HDR_SYNC_LSB] = HDR_SYNC;
    hdr[HDR_TXANT_BIT]             = txant;
    hdr[HDR_SEQ_MSB:HDR_SEQ_LSB]   = seq;
    return hdr;
  endfunction

  // Saturating 16-bit event counter step.
  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/pkt_commit_fifo.sv
// Store-and-forward FIFO with speculative write pointer, commit/rollback
// strobes and a registered output stage with valid/ready handshake.
module pkt_commit_fifo
  import ul_path_pkt_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  fifo_entry_t wr_entry,
  input  logic        commit,
  input  logic        rollback,
  output logic        full_w,
  output logic        full_c,
  output fifo_entry_t rd_entry,
  output logic        rd_valid,
  input  logic        rd_ready
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  fifo_entry_t mem_r [DEPTH];
  logic [AW:0] wptr_r;
  logic [AW:0] wcommit_r;
  logic [AW:0] rptr_r;
  logic [AW:0] base_s;
  logic [AW:0] wptr_nxt_s;
  logic        avail_s;
  logic        load_s;
  fifo_entry_t out_r;
  logic        out_vld_r;

  // A rollback rewinds first, so a header written in the same cycle lands at wcommit.
  assign base_s     = rollback ? wcommit_r : wptr_r;
  assign wptr_nxt_s = base_s + {{AW{1'b0}}, wr_en};
  assign full_w     = (wptr_r - rptr_r) == DEPTH_P;
  assign full_c     = (wcommit_r - rptr_r) == DEPTH_P;
  assign avail_s    = rptr_r != wcommit_r;
  assign load_s     = avail_s && (!out_vld_r || rd_ready);
  assign rd_entry   = out_r;
  assign rd_valid   = out_vld_r;

  // Payload storage; contents are only meaningful between rptr and wptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[base_s[AW-1:0]] <= wr_entry;
    end
  end

  // Write-side pointers: speculative wptr and committed wcommit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r    <= '0;
      wcommit_r <= '0;
    end else begin
      wptr_r <= wptr_nxt_s;
      if (commit) begin
        wcommit_r <= wptr_nxt_s;
      end
    end
  end

  // Read side: prefetch one committed entry into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_r    <= '0;
      out_r     <= '0;
      out_vld_r <= 1'b0;
    end else if (load_s) begin
      out_r     <= mem_r[rptr_r[AW-1:0]];
      out_vld_r <= 1'b1;
      rptr_r    <= rptr_r + {{AW{1'b0}}, 1'b1};
    end else if (rd_ready) begin
      out_vld_r <= 1'b0;
    end
  end

endmodule

// File: rtl/ul_path_pkt_pack.sv
// Uplink-path packetizer: one header-prefixed packet per frame, written into a
// commit/rollback FIFO so only complete packets reach the valid/ready output.
module ul_path_pkt_pack
  import ul_path_pkt_pkg::*;
#(
  parameter int PKT_WORDS = 64,
  parameter int DEPTH     = 256
) (
  input  logic        clk,
  input  logic        asy_rst,
  input  logic [31:0] i_path_tdata,
  input  logic        i_path_tvld,
  input  logic        i_path_tfram,
  input  logic        i_path_txant,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_tsop,
  output logic        o_teop,
  output logic [15:0] o_pkt_cnt,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_long_cnt
);

  localparam int            CW     = $clog2(PKT_WORDS + 1);
  localparam logic [CW-1:0] N_FULL = CW'(PKT_WORDS);
  localparam logic [CW-1:0] N_HALF = CW'(PKT_WORDS / 2);

  pack_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [CW-1:0] n_r, n_s;
  logic [31:0]   skid_r, skid_s;
  logic          skid_vld_r, skid_vld_s;
  logic [15:0]   seq_r, seq_s;
  logic [15:0]   pkt_cnt_r, drop_cnt_r, long_cnt_r;
  logic          head_s, last_s;
  logic          wr_en_s, commit_s, rollback_s;
  fifo_entry_t   wr_entry_s;
  logic [1:0]    drop_inc_s;
  logic          long_inc_s, pkt_inc_s;
  logic          full_w_s, full_c_s;
  fifo_entry_t   rd_entry_s;
  logic          rd_valid_s;

  assign head_s = i_path_tvld & i_path_tfram;
  assign last_s = (cnt_r + CW'(1)) == n_r;

  // Next-state, FIFO write control and counter events.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    n_s        = n_r;
    skid_s     = skid_r;
    skid_vld_s = 1'b0;
    seq_s      = seq_r;
    wr_en_s    = 1'b0;
    wr_entry_s = '0;
    commit_s   = 1'b0;
    rollback_s = 1'b0;
    drop_inc_s = 2'd0;
    long_inc_s = 1'b0;
    pkt_inc_s  = 1'b0;
    if (head_s) begin
      // Outside PAY wptr already equals wcommit, so the rewind is harmless there.
      seq_s      = seq_r + 16'd1;
      n_s        = i_path_txant ? N_FULL : N_HALF;
      rollback_s = 1'b1;
      if (state_r == ST_PAY) begin
        drop_inc_s = 2'd1;
      end else begin
        drop_inc_s = 2'd0;
      end
      if (full_c_s) begin
        drop_inc_s = drop_inc_s + 2'd1;
        state_s    = ST_DROP;
      end else begin
        wr_en_s    = 1'b1;
        wr_entry_s = {1'b1, 1'b0, build_hdr(i_path_txant, seq_r)};
        skid_s     = i_path_tdata;
        skid_vld_s = 1'b1;
        cnt_s      = CW'(1);
        state_s    = ST_PAY;
      end
    end else begin
      case (state_r)
        ST_PAY: begin
          if (skid_vld_r || i_path_tvld) begin
            if (full_w_s) begin
              rollback_s = 1'b1;
              drop_inc_s = 2'd1;
              state_s    = ST_DROP;
            end else if (skid_vld_r) begin
              wr_en_s    = 1'b1;
              wr_entry_s = {1'b0, 1'b0, skid_r};
            end else begin
              wr_en_s    = 1'b1;
              wr_entry_s = {1'b0, last_s, i_path_tdata};
              cnt_s      = cnt_r + CW'(1);
              if (last_s) begin
                commit_s  = 1'b1;
                pkt_inc_s = 1'b1;
                state_s   = ST_WAIT;
              end else begin
                state_s = ST_PAY;
              end
            end
          end else begin
            state_s = ST_PAY;
          end
        end
        ST_WAIT: long_inc_s = i_path_tvld;
        ST_IDLE, ST_DROP: state_s = state_r;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // FSM, skid and counter registers.
  always_ff @(posedge clk or negedge asy_rst) begin
    if (!asy_rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      n_r        <= N_FULL;
      skid_r     <= 32'h0000_0000;
      skid_vld_r <= 1'b0;
      seq_r      <= 16'h0000;
      pkt_cnt_r  <= 16'h0000;
      drop_cnt_r <= 16'h0000;
      long_cnt_r <= 16'h0000;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      n_r        <= n_s;
      skid_r     <= skid_s;
      skid_vld_r <= skid_vld_s;
      seq_r      <= seq_s;
      pkt_cnt_r  <= pkt_cnt_r + {15'd0, pkt_inc_s};
      drop_cnt_r <= sat_add16(drop_cnt_r, drop_inc_s);
      long_cnt_r <= sat_add16(long_cnt_r, {1'b0, long_inc_s});
    end
  end

  pkt_commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (asy_rst),
    .wr_en    (wr_en_s),
    .wr_entry (wr_entry_s),
    .commit   (commit_s),
    .rollback (rollback_s),
    .full_w   (full_w_s),
    .full_c   (full_c_s),
    .rd_entry (rd_entry_s),
    .rd_valid (rd_valid_s),
    .rd_ready (i_tready)
  );

  assign o_tdata    = rd_entry_s.data;
  assign o_tsop     = rd_entry_s.sop;
  assign o_teop     = rd_entry_s.eop;
  assign o_tvalid   = rd_valid_s;
  assign o_pkt_cnt  = pkt_cnt_r;
  assign o_drop_cnt = drop_cnt_r;
  assign o_long_cnt = long_cnt_r;

endmodule

// File: tb/tb_ul_path_pkt_pack.sv
// Bench for ul_path_pkt_pack: frame table plus overflow, backpressure and
// mid-packet reset sequences, checked against a scoreboard of expected words.
module tb_ul_path_pkt_pack;

  logic        clk = 1'b0;
  logic        asy_rst;
  logic [31:0] i_path_tdata;
  logic        i_path_tvld;
  logic        i_path_tfram;
  logic        i_path_txant;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_tsop;
  logic        o_teop;
  logic [15:0] o_pkt_cnt;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_long_cnt;

  int          tests = 0;
  int          fails = 0;
  int          xfer_cnt = 0;
  bit          rand_mode = 1'b0;
  logic [33:0] sb[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;
  int          seq_model = 0;
  int          exp_pkt = 0;
  int          exp_drop = 0;
  int          exp_long = 0;

  typedef struct {
    logic txant;
    int   nwords;
    logic commit;
    int   drop;
    int   lng;
  } row_t;
  row_t tbl[8];

  ul_path_pkt_pack dut (
    .clk          (clk),
    .asy_rst      (asy_rst),
    .i_path_tdata (i_path_tdata),
    .i_path_tvld  (i_path_tvld),
    .i_path_tfram (i_path_tfram),
    .i_path_txant (i_path_txant),
    .o_tdata      (o_tdata),
    .o_tvalid     (o_tvalid),
    .i_tready     (i_tready),
    .o_tsop       (o_tsop),
    .o_teop       (o_teop),
    .o_pkt_cnt    (o_pkt_cnt),
    .o_drop_cnt   (o_drop_cnt),
    .o_long_cnt   (o_long_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pword(input int seq, input int i);
    return {8'(seq), 8'h5A, 16'(i)};
  endfunction

  function automatic logic [31:0] hdr(input logic txant, input int seq);
    return {8'hA5, txant, 7'h00, 16'(seq)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [33:0] exp;
    if (!asy_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", 64'({o_tvalid, o_tsop, o_teop, o_tdata}), 64'({1'b1, prev_word}));
      end
      if (o_tvalid && i_tready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got %h, expected no word", {o_tsop, o_teop, o_tdata});
        end else begin
          exp = sb.pop_front();
          chk("out_word", 64'({o_tsop, o_teop, o_tdata}), 64'(exp));
        end
      end
      prev_stall = o_tvalid && !i_tready;
      prev_word  = {o_tsop, o_teop, o_tdata};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_mode) i_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_pkt(input logic txant, input int seq);
    int n;
    n = txant ? 64 : 32;
    sb.push_back({1'b1, 1'b0, hdr(txant, seq)});
    for (int i = 0; i < n; i++) sb.push_back({1'b0, (i == n - 1), pword(seq, i)});
  endtask

  // Words on every other cycle; idle cycles carry junk data and stray frame flags.
  task automatic run_frame(input logic txant, input int nwords, input logic commit);
    if (commit) push_pkt(txant, seq_model);
    for (int i = 0; i < nwords; i++) begin
      i_path_tvld  = 1'b1;
      i_path_tfram = (i == 0);
      i_path_txant = txant;
      i_path_tdata = pword(seq_model, i);
      tick();
      i_path_tvld  = 1'b0;
      i_path_tfram = ((i % 7) == 3);
      i_path_txant = ~txant;
      i_path_tdata = 32'hDEAD_BEEF;
      tick();
    end
    i_path_tfram = 1'b0;
    seq_model++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_left"}, 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (4) tick();
  endtask

  task automatic chk_cnts(input string name);
    chk({name, "_pkt"},  64'(o_pkt_cnt),  64'(exp_pkt));
    chk({name, "_drop"}, 64'(o_drop_cnt), 64'(exp_drop));
    chk({name, "_long"}, 64'(o_long_cnt), 64'(exp_long));
  endtask

  initial begin
    int pending;
    int xb;
    asy_rst      = 1'b0;
    i_path_tdata = 32'h0;
    i_path_tvld  = 1'b0;
    i_path_tfram = 1'b0;
    i_path_txant = 1'b0;
    i_tready     = 1'b1;
    tbl[0] = '{1'b1, 64, 1'b1, 0, 0};
    tbl[1] = '{1'b1, 64, 1'b1, 0, 0};
    tbl[2] = '{1'b1, 64, 1'b1, 0, 0};
    tbl[3] = '{1'b0, 32, 1'b1, 0, 0};
    tbl[4] = '{1'b1, 40, 1'b0, 1, 0};
    tbl[5] = '{1'b1, 64, 1'b1, 0, 0};
    tbl[6] = '{1'b1, 70, 1'b1, 0, 6};
    tbl[7] = '{1'b0, 35, 1'b1, 0, 3};

    repeat (3) tick();
    chk("rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_tdata",  64'(o_tdata),  64'd0);
    chk("rst_tsop",   64'(o_tsop),   64'd0);
    chk("rst_teop",   64'(o_teop),   64'd0);
    chk_cnts("rst");
    asy_rst = 1'b1;
    repeat (2) tick();
    chk("idle_tvalid", 64'(o_tvalid), 64'd0);

    // A row's early-head drop is only counted when the next row's head arrives.
    pending = 0;
    for (int r = 0; r < 8; r++) begin
      run_frame(tbl[r].txant, tbl[r].nwords, tbl[r].commit);
      exp_drop += pending;
      pending   = tbl[r].drop;
      exp_pkt  += int'(tbl[r].commit);
      exp_long += tbl[r].lng;
      repeat (2) tick();
      chk_cnts($sformatf("row%0d", r));
    end
    drain("table");

    i_tready = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 5; k++) run_frame(1'b1, 64, (k < 3));
    exp_pkt  += 3;
    exp_drop += 2;
    repeat (2) tick();
    chk_cnts("ovf");
    xb = xfer_cnt;
    i_tready = 1'b1;
    drain("ovf");
    chk("ovf_drain_words", 64'(xfer_cnt - xb), 64'd195);

    rand_mode = 1'b1;
    run_frame(1'b1, 64, 1'b1);
    run_frame(1'b0, 32, 1'b1);
    exp_pkt += 2;
    drain("bp");
    rand_mode = 1'b0;
    i_tready  = 1'b1;
    tick();
    chk_cnts("bp");

    i_tready = 1'b0;
    run_frame(1'b1, 64, 1'b1);
    run_frame(1'b1, 20, 1'b0);
    chk("pre_rst_tvalid", 64'(o_tvalid), 64'd1);
    asy_rst = 1'b0;
    #2;
    chk("mid_rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("mid_rst_tdata",  64'(o_tdata),  64'd0);
    chk("mid_rst_tsop",   64'(o_tsop),   64'd0);
    chk("mid_rst_teop",   64'(o_teop),   64'd0);
    sb.delete();
    seq_model = 0;
    exp_pkt   = 0;
    exp_drop  = 0;
    exp_long  = 0;
    chk_cnts("mid_rst");
    repeat (2) tick();
    asy_rst  = 1'b1;
    i_tready = 1'b1;
    tick();
    run_frame(1'b1, 64, 1'b1);
    exp_pkt = 1;
    drain("post_rst");
    chk_cnts("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
